// File: rtl/pconv_c6_sched_pkg.sv
// Shared constants and FSM encoding for the 6-channel pointwise conv sequencer.
package pconv_c6_sched_pkg;

  localparam int PCONV_N         = 16;
  localparam int PCONV_PIXELS    = 64;
  localparam int PCONV_OUT_CH    = 16;
  localparam int PCONV_DRAIN_MAX = 32;
  localparam int PCONV_FM_AW     = $clog2(PCONV_PIXELS);
  localparam int PCONV_OC_AW     = $clog2(PCONV_OUT_CH);
  localparam int PCONV_OFM_AW    = $clog2(PCONV_PIXELS * PCONV_OUT_CH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } pconv_state_e;

endpackage

// File: rtl/pconv_c6_sched_if.sv
// Control, memory and unit-side signals of the pointwise conv sequencer.
interface pconv_c6_sched_if
  import pconv_c6_sched_pkg::*;
#(
  parameter int N      = PCONV_N,
  parameter int FM_AW  = PCONV_FM_AW,
  parameter int OC_AW  = PCONV_OC_AW,
  parameter int OFM_AW = PCONV_OFM_AW
);
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              fmap_rd_en;
  logic [FM_AW-1:0]  fmap_addr;
  logic [6*N-1:0]    fmap_rdata;
  logic              wgt_rd_en;
  logic [OC_AW-1:0]  wgt_addr;
  logic [6*N-1:0]    wgt_rdata;
  logic [31:0]       bias_rdata;
  logic [4:0]        shift_rdata;
  logic              unit_ce;
  logic              unit_input_vld;
  logic [6*N-1:0]    unit_input_din;
  logic [6*N-1:0]    unit_weight_din;
  logic [31:0]       unit_bias_din;
  logic [4:0]        unit_shift_din;
  logic [N-1:0]      unit_dout;
  logic              unit_dout_vld;
  logic              ofm_we;
  logic [OFM_AW-1:0] ofm_addr;
  logic [N-1:0]      ofm_wdata;

  // Sequencer side
  modport master (
    input  start, fmap_rdata, wgt_rdata, bias_rdata, shift_rdata, unit_dout, unit_dout_vld,
    output busy, done, err, fmap_rd_en, fmap_addr, wgt_rd_en, wgt_addr,
           unit_ce, unit_input_vld, unit_input_din, unit_weight_din, unit_bias_din,
           unit_shift_din, ofm_we, ofm_addr, ofm_wdata
  );

  // Environment side (controller, memories, conv unit)
  modport slave (
    output start, fmap_rdata, wgt_rdata, bias_rdata, shift_rdata, unit_dout, unit_dout_vld,
    input  busy, done, err, fmap_rd_en, fmap_addr, wgt_rd_en, wgt_addr,
           unit_ce, unit_input_vld, unit_input_din, unit_weight_din, unit_bias_din,
           unit_shift_din, ofm_we, ofm_addr, ofm_wdata
  );
endinterface

// File: rtl/pconv_c6_sched_inflight.sv
// Tracks results still inside the conv unit and times out a stalled drain.
module pconv_inflight_cnt
  import pconv_c6_sched_pkg::*;
#(
  parameter int PIXELS    = PCONV_PIXELS,
  parameter int DRAIN_MAX = PCONV_DRAIN_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  input  logic drain_en,
  output logic empty,
  output logic underflow,
  output logic timeout
);
  localparam int CW = $clog2(PIXELS + 1);
  localparam int TW = $clog2(DRAIN_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] drain_cnt_q, drain_cnt_d;

  // A result with nothing outstanding is not counted down, so the counter never wraps.
  assign underflow = dec && (cnt_q == '0);
  // An issue entering the unit this cycle still counts as outstanding.
  assign empty     = (cnt_q == '0) && !inc;
  assign timeout   = drain_en && !empty && (drain_cnt_q == TW'(DRAIN_MAX - 1));

  // Next count: up on issue, down on accepted result, drain timer runs only while draining.
  always_comb begin
    cnt_d       = cnt_q;
    drain_cnt_d = '0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(dec && !underflow)) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!inc && dec && !underflow) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (drain_en && !clr) begin
      drain_cnt_d = drain_cnt_q + TW'(1);
    end
  end

  // Register counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      drain_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end
endmodule

// File: rtl/pconv_c6_sched.sv
// Sequencer: loops output channels x pixels, feeds the conv unit, writes results to the ofm RAM.
module pconv_c6_sched
  import pconv_c6_sched_pkg::*;
#(
  parameter int N         = PCONV_N,
  parameter int PIXELS    = PCONV_PIXELS,
  parameter int OUT_CH    = PCONV_OUT_CH,
  parameter int DRAIN_MAX = PCONV_DRAIN_MAX
) (
  input  logic clk,
  input  logic rst_n,
  pconv_c6_sched_if.master bus
);
  localparam int FM_AW  = $clog2(PIXELS);
  localparam int OC_AW  = $clog2(OUT_CH);
  localparam int OFM_AW = $clog2(PIXELS * OUT_CH);

  pconv_state_e      state_q, state_d;
  logic              load_ph_q, load_ph_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              fmap_rd_en_q, fmap_rd_en_d, wgt_rd_en_q, wgt_rd_en_d;
  logic [FM_AW-1:0]  fmap_addr_q, fmap_addr_d;   // issue pixel
  logic [OC_AW-1:0]  wgt_addr_q, wgt_addr_d;     // current output channel
  logic              input_vld_q, input_vld_d;
  logic [6*N-1:0]    weight_q, weight_d;
  logic [31:0]       bias_q, bias_d;
  logic [4:0]        shift_q, shift_d;
  logic              ofm_we_q, ofm_we_d;
  logic [OFM_AW-1:0] ofm_addr_q, ofm_addr_d;
  logic [N-1:0]      ofm_wdata_q, ofm_wdata_d;
  logic [FM_AW-1:0]  wr_pix_q, wr_pix_d;
  logic [OC_AW-1:0]  oc_wr_q, oc_wr_d;
  logic              accept, empty, underflow, timeout;

  assign accept = (state_q == ST_IDLE) && bus.start;

  pconv_inflight_cnt #(.PIXELS(PIXELS), .DRAIN_MAX(DRAIN_MAX)) u_inflight (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .inc      (input_vld_q),
    .dec      (bus.unit_dout_vld),
    .drain_en (state_q == ST_DRAIN),
    .empty    (empty),
    .underflow(underflow),
    .timeout  (timeout)
  );

  // Next-state logic for the FSM, issue/load counters and the result write register.
  always_comb begin
    state_d      = state_q;
    load_ph_d    = load_ph_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q | underflow | timeout;
    fmap_rd_en_d = fmap_rd_en_q;
    fmap_addr_d  = fmap_addr_q;
    wgt_rd_en_d  = 1'b0;
    wgt_addr_d   = wgt_addr_q;
    input_vld_d  = fmap_rd_en_q;          // fmap data returns one cycle after the read
    weight_d     = weight_q;
    bias_d       = bias_q;
    shift_d      = shift_q;
    ofm_we_d     = 1'b0;
    ofm_addr_d   = ofm_addr_q;
    ofm_wdata_d  = ofm_wdata_q;
    wr_pix_d     = wr_pix_q;
    oc_wr_d      = oc_wr_q;

    // Results land in issue order, so the write address is just a running pixel/channel count.
    if (bus.unit_dout_vld && !underflow) begin
      ofm_we_d    = 1'b1;
      ofm_wdata_d = bus.unit_dout;
      ofm_addr_d  = OFM_AW'(oc_wr_q) * OFM_AW'(PIXELS) + OFM_AW'(wr_pix_q);
      if (wr_pix_q == FM_AW'(PIXELS - 1)) begin
        wr_pix_d = '0;
        oc_wr_d  = oc_wr_q + OC_AW'(1);
      end else begin
        wr_pix_d = wr_pix_q + FM_AW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_LOAD;
          load_ph_d   = 1'b0;
          busy_d      = 1'b1;
          err_d       = 1'b0;
          wgt_rd_en_d = 1'b1;
          wgt_addr_d  = '0;
          fmap_addr_d = '0;
          wr_pix_d    = '0;
          oc_wr_d     = '0;
        end
      end
      ST_LOAD: begin
        if (!load_ph_q) begin
          load_ph_d = 1'b1;
        end else begin
          weight_d     = bus.wgt_rdata;
          bias_d       = bus.bias_rdata;
          shift_d      = bus.shift_rdata;
          state_d      = ST_ISSUE;
          fmap_rd_en_d = 1'b1;
          fmap_addr_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (fmap_addr_q == FM_AW'(PIXELS - 1)) begin
          fmap_rd_en_d = 1'b0;
          state_d      = ST_DRAIN;
        end else begin
          fmap_addr_d = fmap_addr_q + FM_AW'(1);
        end
      end
      ST_DRAIN: begin
        // Parameters stay frozen until every result of this channel has come back.
        if (timeout) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (empty) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (wgt_addr_q == OC_AW'(OUT_CH - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          wgt_addr_d  = wgt_addr_q + OC_AW'(1);
          fmap_addr_d = '0;
          wgt_rd_en_d = 1'b1;
          load_ph_d   = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      load_ph_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      fmap_rd_en_q <= 1'b0;
      fmap_addr_q  <= '0;
      wgt_rd_en_q  <= 1'b0;
      wgt_addr_q   <= '0;
      input_vld_q  <= 1'b0;
      weight_q     <= '0;
      bias_q       <= '0;
      shift_q      <= '0;
      ofm_we_q     <= 1'b0;
      ofm_addr_q   <= '0;
      ofm_wdata_q  <= '0;
      wr_pix_q     <= '0;
      oc_wr_q      <= '0;
    end else begin
      state_q      <= state_d;
      load_ph_q    <= load_ph_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      fmap_rd_en_q <= fmap_rd_en_d;
      fmap_addr_q  <= fmap_addr_d;
      wgt_rd_en_q  <= wgt_rd_en_d;
      wgt_addr_q   <= wgt_addr_d;
      input_vld_q  <= input_vld_d;
      weight_q     <= weight_d;
      bias_q       <= bias_d;
      shift_q      <= shift_d;
      ofm_we_q     <= ofm_we_d;
      ofm_addr_q   <= ofm_addr_d;
      ofm_wdata_q  <= ofm_wdata_d;
      wr_pix_q     <= wr_pix_d;
      oc_wr_q      <= oc_wr_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;
  assign bus.fmap_rd_en      = fmap_rd_en_q;
  assign bus.fmap_addr       = fmap_addr_q;
  assign bus.wgt_rd_en       = wgt_rd_en_q;
  assign bus.wgt_addr        = wgt_addr_q;
  assign bus.unit_ce         = busy_q;
  assign bus.unit_input_vld  = input_vld_q;
  assign bus.unit_input_din  = bus.fmap_rdata;
  assign bus.unit_weight_din = weight_q;
  assign bus.unit_bias_din   = bias_q;
  assign bus.unit_shift_din  = shift_q;
  assign bus.ofm_we          = ofm_we_q;
  assign bus.ofm_addr        = ofm_addr_q;
  assign bus.ofm_wdata       = ofm_wdata_q;
endmodule

// File: tb/tb_pconv_c6_sched.sv
// Bench: memory + conv-unit models around the sequencer, golden ofm computed per (oc, pixel).
module tb_pconv_c6_sched;
  localparam int N = 16, P = 4, OC = 2, LOG = 512;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pconv_c6_sched_if #(.N(N), .FM_AW(2), .OC_AW(1), .OFM_AW(3)) bus ();

  pconv_c6_sched #(.N(N), .PIXELS(P), .OUT_CH(OC), .DRAIN_MAX(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [6*N-1:0] fmap_mem [P];
  logic [6*N-1:0] wgt_mem  [OC];
  logic [31:0]    bias_mem [OC];
  logic [4:0]     shift_mem[OC];

  int errors = 0, checks = 0;
  int wr_cnt = 0, done_cnt = 0;
  int log_addr[LOG], log_data[LOG];
  logic spur = 1'b0;
  int drop_idx = -1;

  function automatic longint dot6(input logic [6*N-1:0] x, input logic [6*N-1:0] w);
    longint s = 0;
    for (int i = 0; i < 6; i++)
      s += longint'($signed(x[i*N +: N])) * longint'($signed(w[i*N +: N]));
    return s;
  endfunction

  function automatic logic [N-1:0] relu_q(input longint d, input logic [31:0] b, input logic [4:0] sh);
    longint a = d + longint'($signed(b));
    a = a >>> sh;
    if (a < 0) a = 0;
    if (a > 32767) a = 32767;
    return N'(a);
  endfunction

  // Expected ofm word at flat address k = oc*P + pixel.
  function automatic logic [N-1:0] golden(input int k);
    int oc = k / P, p = k % P;
    return relu_q(dot6(fmap_mem[p], wgt_mem[oc]), bias_mem[oc], shift_mem[oc]);
  endfunction

  // Memories: one-cycle registered read.
  always @(posedge clk) begin
    if (bus.fmap_rd_en) bus.fmap_rdata <= fmap_mem[bus.fmap_addr];
    if (bus.wgt_rd_en) begin
      bus.wgt_rdata   <= wgt_mem[bus.wgt_addr];
      bus.bias_rdata  <= bias_mem[bus.wgt_addr];
      bus.shift_rdata <= shift_mem[bus.wgt_addr];
    end
  end

  // Conv unit: 3-cycle latency; dot product taken at input, bias/shift applied at output.
  logic   vld_s0, vld_s1, out_vld;
  longint dot_s0, dot_s1, out_dot;
  int     res_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      vld_s0 <= 1'b0; vld_s1 <= 1'b0; out_vld <= 1'b0; res_cnt <= 0;
      dot_s0 <= 0; dot_s1 <= 0; out_dot <= 0;
    end else begin
      vld_s0  <= bus.unit_input_vld;
      dot_s0  <= dot6(bus.unit_input_din, bus.unit_weight_din);
      vld_s1  <= vld_s0;
      dot_s1  <= dot_s0;
      out_dot <= dot_s1;
      out_vld <= vld_s1 && (res_cnt != drop_idx);
      if (bus.start) res_cnt <= 0;
      else if (vld_s1) res_cnt <= res_cnt + 1;
    end
  end
  assign bus.unit_dout_vld = out_vld | spur;
  assign bus.unit_dout     = relu_q(out_dot, bus.unit_bias_din, bus.unit_shift_din);

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus.ofm_we) begin
      if (wr_cnt < LOG) begin
        log_addr[wr_cnt] = int'(bus.ofm_addr);
        log_data[wr_cnt] = int'(bus.ofm_wdata);
      end
      wr_cnt++;
      $display("ofm write #%0d addr=%0d data=%0d", wr_cnt, bus.ofm_addr, bus.ofm_wdata);
    end
    if (rst_n && bus.done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_mem();
    for (int k = 0; k < P; k++)
      for (int c = 0; c < 6; c++) begin
        int t = int'($urandom_range(0, 400)) - 200;
        fmap_mem[k][c*N +: N] = t[N-1:0];
      end
    for (int o = 0; o < OC; o++) begin
      int b = int'($urandom_range(0, 40000)) - 20000;
      for (int c = 0; c < 6; c++) begin
        int t = int'($urandom_range(0, 400)) - 200;
        wgt_mem[o][c*N +: N] = t[N-1:0];
      end
      bias_mem[o]  = b;
      shift_mem[o] = 5'($urandom_range(0, 7));
    end
  endtask

  task automatic start_pulse();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; optionally re-pulse start while busy.
  task automatic wait_done(input string tag, input int restart_at);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      bus.start = (i == restart_at);
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic check_run(input string tag, input int bw, input int bd);
    repeat (3) @(negedge clk);
    chk({tag, "_wr_count"}, 64'(wr_cnt - bw), 64'(P * OC));
    chk({tag, "_done_count"}, 64'(done_cnt - bd), 64'd1);
    chk({tag, "_err"}, 64'(bus.err), 64'd0);
    for (int k = 0; k < P * OC; k++) begin
      if (bw + k < LOG) begin
        chk($sformatf("%s_addr%0d", tag, k), 64'(log_addr[bw + k]), 64'(k));
        chk($sformatf("%s_data%0d", tag, k), 64'(log_data[bw + k]), 64'(golden(k)));
      end
    end
  endtask

  initial begin
    int bw, bd;
    bit found;
    rst_n = 1'b0; bus.start = 1'b0;
    rand_mem();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Reset state
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_ofm_we", 64'(bus.ofm_we), 64'd0);
    chk("rst_fmap_rd_en", 64'(bus.fmap_rd_en), 64'd0);
    chk("rst_wgt_rd_en", 64'(bus.wgt_rd_en), 64'd0);
    chk("rst_input_vld", 64'(bus.unit_input_vld), 64'd0);
    chk("rst_ofm_addr", 64'(bus.ofm_addr), 64'd0);

    // 1: random layer
    bw = wr_cnt; bd = done_cnt;
    start_pulse();
    chk("t1_busy_after_start", 64'(bus.busy), 64'd1);
    wait_done("t1", -1);
    check_run("t1", bw, bd);

    // 2: ReLU clamp on oc0; oc1 bias large positive so an early bias swap would show at addr 3
    for (int k = 0; k < P; k++)
      for (int c = 0; c < 6; c++) fmap_mem[k][c*N +: N] = N'(10 + k);
    for (int c = 0; c < 6; c++) begin
      wgt_mem[0][c*N +: N] = -16'sd2;
      wgt_mem[1][c*N +: N] = 16'sd3;
    end
    bias_mem[0] = -32'sd1000; shift_mem[0] = 5'd4;
    bias_mem[1] = 32'sd5000;  shift_mem[1] = 5'd4;
    bw = wr_cnt; bd = done_cnt;
    start_pulse();
    wait_done("t2", -1);
    check_run("t2", bw, bd);
    chk("t2_relu_addr3", 64'(log_data[bw + 3]), 64'd0);

    // 3: start re-pulsed while busy is ignored
    rand_mem();
    bw = wr_cnt; bd = done_cnt;
    start_pulse();
    wait_done("t3", 5);
    check_run("t3", bw, bd);

    // 5: spurious result in IDLE sets err, no write; next start clears err
    bw = wr_cnt;
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    chk("t5_err_set", 64'(bus.err), 64'd1);
    chk("t5_no_we", 64'(bus.ofm_we), 64'd0);
    @(negedge clk);
    chk("t5_no_we2", 64'(bus.ofm_we), 64'd0);
    chk("t5_wr_count", 64'(wr_cnt - bw), 64'd0);
    rand_mem();
    bw = wr_cnt; bd = done_cnt;
    start_pulse();
    chk("t5_err_cleared", 64'(bus.err), 64'd0);
    wait_done("t5b", -1);
    check_run("t5b", bw, bd);

    // 4: one dropped result -> drain timeout abort
    drop_idx = 2;
    bw = wr_cnt; bd = done_cnt;
    start_pulse();
    wait_done("t4", -1);
    chk("t4_err", 64'(bus.err), 64'd1);
    repeat (3) @(negedge clk);
    chk("t4_wr_count", 64'(wr_cnt - bw), 64'(P - 1));
    chk("t4_done_count", 64'(done_cnt - bd), 64'd1);
    chk("t4_busy", 64'(bus.busy), 64'd0);
    drop_idx = -1;

    // 6: reset during ISSUE at pixel 2, then a clean layer
    rand_mem();
    bd = done_cnt;
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.fmap_rd_en && bus.fmap_addr == 2'd2) found = 1'b1;
    end
    chk("t6_reached_pix2", 64'(found), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy_after_rst", 64'(bus.busy), 64'd0);
    chk("t6_no_done", 64'(bus.done), 64'd0);
    chk("t6_done_count", 64'(done_cnt - bd), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bw = wr_cnt; bd = done_cnt;
    start_pulse();
    wait_done("t6b", -1);
    check_run("t6b", bw, bd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
